// File: rtl/disp_timing_gen.sv
// Runtime-programmable display timing generator: H/V segment FSMs, shadowed timing
// registers swapped in at frame boundaries, and a uniform output delay line.
module disp_timing_gen #(
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned OUT_DLY    = 2,
    parameter int unsigned RST_HPULSE = 1,
    parameter int unsigned RST_HBP    = 3,
    parameter int unsigned RST_HRES   = 4,
    parameter int unsigned RST_HFP    = 5,
    parameter int unsigned RST_VPULSE = 1,
    parameter int unsigned RST_VBP    = 3,
    parameter int unsigned RST_VRES   = 4,
    parameter int unsigned RST_VFP    = 5
) (
    input  logic             i_clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_cfg_we,
    input  logic [CNT_W-1:0] i_cfg_hpulse,
    input  logic [CNT_W-1:0] i_cfg_hbp,
    input  logic [CNT_W-1:0] i_cfg_hres,
    input  logic [CNT_W-1:0] i_cfg_hfp,
    input  logic [CNT_W-1:0] i_cfg_vpulse,
    input  logic [CNT_W-1:0] i_cfg_vbp,
    input  logic [CNT_W-1:0] i_cfg_vres,
    input  logic [CNT_W-1:0] i_cfg_vfp,
    input  logic             i_cfg_hpol,
    input  logic             i_cfg_vpol,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_frame_start,
    output logic             o_cfg_pending
);

    typedef enum logic [2:0] {
        StIdle,
        StPulse,
        StBp,
        StActive,
        StFp
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0] hpulse;
        logic [CNT_W-1:0] hbp;
        logic [CNT_W-1:0] hres;
        logic [CNT_W-1:0] hfp;
        logic [CNT_W-1:0] vpulse;
        logic [CNT_W-1:0] vbp;
        logic [CNT_W-1:0] vres;
        logic [CNT_W-1:0] vfp;
        logic             hpol;
        logic             vpol;
    } timing_t;

    typedef struct packed {
        logic             hsync;
        logic             vsync;
        logic             de;
        logic             fs;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
    } out_t;

    localparam timing_t RstTiming = '{
        hpulse: CNT_W'(RST_HPULSE),
        hbp:    CNT_W'(RST_HBP),
        hres:   CNT_W'(RST_HRES),
        hfp:    CNT_W'(RST_HFP),
        vpulse: CNT_W'(RST_VPULSE),
        vbp:    CNT_W'(RST_VBP),
        vres:   CNT_W'(RST_VRES),
        vfp:    CNT_W'(RST_VFP),
        hpol:   1'b1,
        vpol:   1'b1
    };

    // A zero-length segment behaves as a one-cycle (or one-line) segment.
    function automatic logic [CNT_W-1:0] seg_last(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

    function automatic state_e seg_next(input state_e st);
        case (st)
            StPulse:  return StBp;
            StBp:     return StActive;
            StActive: return StFp;
            StFp:     return StPulse;
            default:  return StIdle;
        endcase
    endfunction

    timing_t          cfg_in;
    timing_t          act_q;
    timing_t          pend_q;
    logic             pend_flag_q;
    state_e           h_state_q;
    state_e           v_state_q;
    logic [CNT_W-1:0] h_cnt_q;
    logic [CNT_W-1:0] v_cnt_q;
    logic [CNT_W-1:0] h_len;
    logic [CNT_W-1:0] v_len;
    logic             h_last;
    logic             v_last;
    logic             line_end;
    logic             frame_end;
    logic             cfg_load;
    out_t             stage0;
    out_t             pipe_q [OUT_DLY];

    assign cfg_in = '{
        hpulse: i_cfg_hpulse,
        hbp:    i_cfg_hbp,
        hres:   i_cfg_hres,
        hfp:    i_cfg_hfp,
        vpulse: i_cfg_vpulse,
        vbp:    i_cfg_vbp,
        vres:   i_cfg_vres,
        vfp:    i_cfg_vfp,
        hpol:   i_cfg_hpol,
        vpol:   i_cfg_vpol
    };

    always_comb begin
        h_len = '0;
        case (h_state_q)
            StPulse:  h_len = act_q.hpulse;
            StBp:     h_len = act_q.hbp;
            StActive: h_len = act_q.hres;
            StFp:     h_len = act_q.hfp;
            default:  h_len = '0;
        endcase
    end

    always_comb begin
        v_len = '0;
        case (v_state_q)
            StPulse:  v_len = act_q.vpulse;
            StBp:     v_len = act_q.vbp;
            StActive: v_len = act_q.vres;
            StFp:     v_len = act_q.vfp;
            default:  v_len = '0;
        endcase
    end

    assign h_last    = (h_cnt_q == seg_last(h_len));
    assign v_last    = (v_cnt_q == seg_last(v_len));
    assign line_end  = (h_state_q == StFp) && h_last;
    assign frame_end = line_end && (v_state_q == StFp) && v_last;
    assign cfg_load  = frame_end || (h_state_q == StIdle);

    // H and V move together: V only steps on the cycle H wraps back into PULSE.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_state_q <= StIdle;
            v_state_q <= StIdle;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
        end else begin
            case (h_state_q)
                StIdle: begin
                    if (i_en) begin
                        h_state_q <= StPulse;
                        v_state_q <= StPulse;
                    end
                end
                default: begin
                    if (frame_end && !i_en) begin
                        h_state_q <= StIdle;
                        v_state_q <= StIdle;
                        h_cnt_q   <= '0;
                        v_cnt_q   <= '0;
                    end else begin
                        if (h_last) begin
                            h_cnt_q   <= '0;
                            h_state_q <= seg_next(h_state_q);
                        end else begin
                            h_cnt_q <= h_cnt_q + CNT_W'(1);
                        end
                        if (line_end) begin
                            if (v_last) begin
                                v_cnt_q   <= '0;
                                v_state_q <= seg_next(v_state_q);
                            end else begin
                                v_cnt_q <= v_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    // A write landing on the load cycle stays pending for the next boundary.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q       <= RstTiming;
            pend_q      <= RstTiming;
            pend_flag_q <= 1'b0;
        end else begin
            if (i_cfg_we) begin
                pend_q <= cfg_in;
            end
            if (cfg_load) begin
                act_q       <= pend_q;
                pend_flag_q <= i_cfg_we;
            end else if (i_cfg_we) begin
                pend_flag_q <= 1'b1;
            end
        end
    end

    // Polarity is folded in before the delay line so it switches with the timing.
    always_comb begin
        stage0       = '0;
        stage0.de    = (h_state_q == StActive) && (v_state_q == StActive);
        stage0.hsync = ~((h_state_q == StPulse) ^ act_q.hpol);
        stage0.vsync = ~((v_state_q == StPulse) ^ act_q.vpol);
        stage0.fs    = (h_state_q == StPulse) && (h_cnt_q == '0) &&
                       (v_state_q == StPulse) && (v_cnt_q == '0);
        stage0.x     = stage0.de ? h_cnt_q : '0;
        stage0.y     = stage0.de ? v_cnt_q : '0;
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(OUT_DLY); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= stage0;
            for (int i = 1; i < int'(OUT_DLY); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign o_hsync       = pipe_q[OUT_DLY-1].hsync;
    assign o_vsync       = pipe_q[OUT_DLY-1].vsync;
    assign o_de          = pipe_q[OUT_DLY-1].de;
    assign o_frame_start = pipe_q[OUT_DLY-1].fs;
    assign o_x           = pipe_q[OUT_DLY-1].x;
    assign o_y           = pipe_q[OUT_DLY-1].y;
    assign o_cfg_pending = pend_flag_q;

endmodule

// File: tb/tb_disp_timing_gen.sv
// Directed bench for disp_timing_gen: default timing, reconfiguration, polarity,
// disable, mid-line reset and zero-length segments.
module tb_disp_timing_gen;

    localparam int CNT_W = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_en = 1'b0;
    logic             i_cfg_we = 1'b0;
    logic [CNT_W-1:0] i_cfg_hpulse, i_cfg_hbp, i_cfg_hres, i_cfg_hfp;
    logic [CNT_W-1:0] i_cfg_vpulse, i_cfg_vbp, i_cfg_vres, i_cfg_vfp;
    logic             i_cfg_hpol, i_cfg_vpol;
    logic             o_hsync, o_vsync, o_de, o_frame_start, o_cfg_pending;
    logic [CNT_W-1:0] o_x, o_y;

    int t;
    int n_checks = 0;
    int n_fail = 0;
    int fs_cnt, fs_first, hs_cnt, hs_first, vs_cnt, de_cnt, de_first, xy_nz;
    int de_x[$];
    int de_y[$];

    always #5 clk = ~clk;

    disp_timing_gen #(
        .CNT_W  (CNT_W),
        .OUT_DLY(2)
    ) dut (
        .i_clk        (clk),
        .rst_n        (rst_n),
        .i_en         (i_en),
        .i_cfg_we     (i_cfg_we),
        .i_cfg_hpulse (i_cfg_hpulse),
        .i_cfg_hbp    (i_cfg_hbp),
        .i_cfg_hres   (i_cfg_hres),
        .i_cfg_hfp    (i_cfg_hfp),
        .i_cfg_vpulse (i_cfg_vpulse),
        .i_cfg_vbp    (i_cfg_vbp),
        .i_cfg_vres   (i_cfg_vres),
        .i_cfg_vfp    (i_cfg_vfp),
        .i_cfg_hpol   (i_cfg_hpol),
        .i_cfg_vpol   (i_cfg_vpol),
        .o_hsync      (o_hsync),
        .o_vsync      (o_vsync),
        .o_de         (o_de),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_frame_start(o_frame_start),
        .o_cfg_pending(o_cfg_pending)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic wait_until(input int tt);
        while (t < tt) tick();
    endtask

    task automatic set_cfg(input int hp, input int hb, input int hr, input int hf,
                           input int vp, input int vb, input int vr, input int vf,
                           input logic hpol, input logic vpol);
        i_cfg_hpulse = CNT_W'(hp);
        i_cfg_hbp    = CNT_W'(hb);
        i_cfg_hres   = CNT_W'(hr);
        i_cfg_hfp    = CNT_W'(hf);
        i_cfg_vpulse = CNT_W'(vp);
        i_cfg_vbp    = CNT_W'(vb);
        i_cfg_vres   = CNT_W'(vr);
        i_cfg_vfp    = CNT_W'(vf);
        i_cfg_hpol   = hpol;
        i_cfg_vpol   = vpol;
    endtask

    task automatic cfg_write(input int hp, input int hb, input int hr, input int hf,
                             input int vp, input int vb, input int vr, input int vf,
                             input logic hpol, input logic vpol);
        set_cfg(hp, hb, hr, hf, vp, vb, vr, vf, hpol, vpol);
        i_cfg_we = 1'b1;
        tick();
        i_cfg_we = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return {3'b0, o_hsync, o_vsync, o_de, o_frame_start, o_cfg_pending, o_x, o_y};
    endfunction

    // Reset, check reset state, then release with i_en high; returns at t0 (t = 0).
    task automatic start();
        rst_n    = 1'b0;
        i_en     = 1'b0;
        i_cfg_we = 1'b0;
        set_cfg(1, 3, 4, 5, 1, 3, 4, 5, 1'b1, 1'b1);
        repeat (3) tick();
        check_eq("reset_outs", all_outs(), 0);
        rst_n = 1'b1;
        i_en  = 1'b1;
        tick();
        t = 0;
    endtask

    task automatic observe(input int n);
        fs_cnt = 0; fs_first = -1; hs_cnt = 0; hs_first = -1;
        vs_cnt = 0; de_cnt = 0; de_first = -1; xy_nz = 0;
        de_x.delete();
        de_y.delete();
        for (int i = 0; i < n; i++) begin
            if (o_frame_start) begin
                if (fs_cnt == 0) fs_first = t;
                fs_cnt++;
            end
            if (o_hsync) begin
                if (hs_cnt == 0) hs_first = t;
                hs_cnt++;
            end
            if (o_vsync) vs_cnt++;
            if (o_de) begin
                if (de_cnt == 0) de_first = t;
                de_cnt++;
                de_x.push_back(int'(o_x));
                de_y.push_back(int'(o_y));
            end else if (o_x != '0 || o_y != '0) begin
                xy_nz++;
            end
            tick();
        end
    endtask

    task automatic check_de_seq(input string tag, input int hres);
        for (int k = 0; k < de_x.size(); k++) begin
            check_eq({tag, "_x"}, de_x[k], k % hres);
            check_eq({tag, "_y"}, de_y[k], k / hres);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        t = 0;
        set_cfg(1, 3, 4, 5, 1, 3, 4, 5, 1'b1, 1'b1);

        // Default timing: 13x13 frame, outputs delayed by two cycles.
        start();
        check_eq("lat_fs_t0", o_frame_start, 0);
        check_eq("lat_hs_t0", o_hsync, 0);
        tick();
        check_eq("lat_fs_t1", o_frame_start, 0);
        tick();
        observe(169);
        check_eq("def_fs_cnt", fs_cnt, 1);
        check_eq("def_fs_first", fs_first, 2);
        check_eq("def_hs_cnt", hs_cnt, 13);
        check_eq("def_hs_first", hs_first, 2);
        check_eq("def_vs_cnt", vs_cnt, 13);
        check_eq("def_de_cnt", de_cnt, 16);
        check_eq("def_de_first", de_first, 58);
        check_eq("def_xy_idle", xy_nz, 0);
        check_de_seq("def", 4);
        check_eq("def_pending", o_cfg_pending, 0);
        observe(169);
        check_eq("def_fs2_first", fs_first, 171);
        check_eq("def_fs2_cnt", fs_cnt, 1);
        check_eq("def_fs3", o_frame_start, 1);

        // Mid-frame reconfiguration: HRES=8, VRES=2 at t0+20.
        start();
        wait_until(20);
        check_eq("rcfg_pend_pre", o_cfg_pending, 0);
        cfg_write(1, 3, 8, 5, 1, 3, 2, 5, 1'b1, 1'b1);
        check_eq("rcfg_pend_set", o_cfg_pending, 1);
        wait_until(168);
        check_eq("rcfg_pend_hold", o_cfg_pending, 1);
        tick();
        check_eq("rcfg_pend_clr", o_cfg_pending, 0);
        wait_until(171);
        observe(187);
        check_eq("rcfg_fs_first", fs_first, 171);
        check_eq("rcfg_fs_cnt", fs_cnt, 1);
        check_eq("rcfg_hs_cnt", hs_cnt, 11);
        check_eq("rcfg_vs_cnt", vs_cnt, 17);
        check_eq("rcfg_de_cnt", de_cnt, 16);
        check_eq("rcfg_de_first", de_first, 243);
        check_de_seq("rcfg", 8);
        check_eq("rcfg_fs_next", o_frame_start, 1);

        // Polarity flip to active-low, applied at the next boundary.
        start();
        wait_until(30);
        cfg_write(1, 3, 4, 5, 1, 3, 4, 5, 1'b0, 1'b0);
        wait_until(170);
        check_eq("pol_old_hs", o_hsync, 0);
        check_eq("pol_old_vs", o_vsync, 0);
        tick();
        check_eq("pol_new_hs_pulse", o_hsync, 0);
        check_eq("pol_new_vs_pulse", o_vsync, 0);
        observe(169);
        check_eq("pol_hs_high", hs_cnt, 156);
        check_eq("pol_vs_high", vs_cnt, 156);
        check_eq("pol_de_cnt", de_cnt, 16);
        check_eq("pol_fs_first", fs_first, 171);
        check_eq("pol_hs_t340", o_hsync, 0);
        tick();
        check_eq("pol_hs_t341", o_hsync, 1);

        // Disable at t0+100: frame completes, then idles.
        start();
        wait_until(100);
        i_en = 1'b0;
        observe(71);
        check_eq("dis_hs_tail", hs_cnt, 5);
        check_eq("dis_de_tail", de_cnt, 1);
        check_eq("dis_fs_tail", fs_cnt, 0);
        observe(30);
        check_eq("dis_idle_hs", hs_cnt, 0);
        check_eq("dis_idle_vs", vs_cnt, 0);
        check_eq("dis_idle_de", de_cnt, 0);
        check_eq("dis_idle_fs", fs_cnt, 0);
        check_eq("dis_idle_xy", xy_nz, 0);
        i_en = 1'b1;
        tick();
        tick();
        check_eq("reen_fs_pre", o_frame_start, 0);
        tick();
        check_eq("reen_fs", o_frame_start, 1);

        // Asynchronous reset in the middle of an active line.
        start();
        wait_until(60);
        check_eq("mrst_de_before", o_de, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_async_outs", all_outs(), 0);
        repeat (3) tick();
        check_eq("mrst_held_outs", all_outs(), 0);
        rst_n = 1'b1;
        tick();
        t = 0;
        tick();
        tick();
        observe(169);
        check_eq("mrst_fs_first", fs_first, 2);
        check_eq("mrst_hs_cnt", hs_cnt, 13);
        check_eq("mrst_de_first", de_first, 58);
        check_eq("mrst_de_cnt", de_cnt, 16);

        // Zero-length HBP and VFP behave as length 1: 11 x 9 frame.
        start();
        wait_until(10);
        cfg_write(1, 0, 4, 5, 1, 3, 4, 0, 1'b1, 1'b1);
        wait_until(171);
        observe(99);
        check_eq("zero_fs_first", fs_first, 171);
        check_eq("zero_fs_cnt", fs_cnt, 1);
        check_eq("zero_hs_cnt", hs_cnt, 9);
        check_eq("zero_vs_cnt", vs_cnt, 11);
        check_eq("zero_de_cnt", de_cnt, 16);
        check_eq("zero_de_first", de_first, 217);
        check_de_seq("zero", 4);
        check_eq("zero_fs_next", o_frame_start, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
